// File: rtl/uart_rx.sv
// UART receiver with 2-flop input synchronizer and OVS-times oversampling.
// Recovers start(0) / WIDTH data bits LSB first / optional parity / stop(1)
// frames and hands the word on with a single-cycle valid strobe.
//
// Ports:
//   CLK        clock; one bit period lasts OVS cycles
//   RST        asynchronous active-low reset
//   RX_IN      serial line, idles high, asynchronous to CLK
//   PAR_EN     1 = frame carries a parity bit (latched at START entry)
//   PAR_TYP    0 = even, 1 = odd parity (latched at START entry)
//   P_DATA     last good received word
//   DATA_VALID one-cycle pulse when P_DATA has just been updated
//   PAR_ERR    parity mismatch on the last completed frame
//   STP_ERR    stop bit sampled low on the last completed frame
//   BUSY       high whenever the receiver is not idle
module uart_rx #(
  parameter int WIDTH = 8,
  parameter int OVS   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RX_IN,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic [WIDTH-1:0] P_DATA,
  output logic             DATA_VALID,
  output logic             PAR_ERR,
  output logic             STP_ERR,
  output logic             BUSY
);

  localparam int EW = $clog2(OVS);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [EW-1:0] SAMP_A    = EW'(OVS / 2 - 1);
  localparam logic [EW-1:0] SAMP_B    = EW'(OVS / 2);
  localparam logic [EW-1:0] SAMP_C    = EW'(OVS / 2 + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(OVS - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e            state_q, state_d;
  logic              sync1_q, sync2_q;
  logic [EW-1:0]     edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              samp_a_q, samp_a_d;
  logic              samp_b_q, samp_b_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic              par_en_q, par_en_d;
  logic              par_typ_q, par_typ_d;
  logic              mismatch_q, mismatch_d;
  logic [WIDTH-1:0]  p_data_q, p_data_d;
  logic              valid_q, valid_d;
  logic              par_err_q, par_err_d;
  logic              stp_err_q, stp_err_d;

  logic              rx_s;
  logic              bit_maj;
  logic              decide;
  logic              last_edge;

  // Two-flop synchronizer; flops reset high so reset never looks like a start bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= RX_IN;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s      = sync2_q;
  assign decide    = (edge_cnt_q == SAMP_C);
  assign last_edge = (edge_cnt_q == LAST_EDGE);

  // Majority of the two stored mid-bit samples and the live third sample,
  // so a single-cycle glitch around the bit centre is voted out.
  assign bit_maj = (samp_a_q & samp_b_q) | (samp_a_q & rx_s) | (samp_b_q & rx_s);

  // All receiver state registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      samp_a_q   <= 1'b1;
      samp_b_q   <= 1'b1;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      mismatch_q <= 1'b0;
      p_data_q   <= '0;
      valid_q    <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      samp_a_q   <= samp_a_d;
      samp_b_q   <= samp_b_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      mismatch_q <= mismatch_d;
      p_data_q   <= p_data_d;
      valid_q    <= valid_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
    end
  end

  // Next-state logic. The stop bit is judged at its centre and the FSM
  // returns to IDLE on that same edge, leaving half a bit of slack so a
  // transmitter sending frames back to back is never missed.
  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    samp_a_d   = samp_a_q;
    samp_b_d   = samp_b_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    mismatch_d = mismatch_q;
    p_data_d   = p_data_q;
    valid_d    = 1'b0;
    par_err_d  = par_err_q;
    stp_err_d  = stp_err_q;

    if (state_q != IDLE) begin
      edge_cnt_d = last_edge ? '0 : edge_cnt_q + 1'b1;
      if (edge_cnt_q == SAMP_A) samp_a_d = rx_s;
      if (edge_cnt_q == SAMP_B) samp_b_d = rx_s;
    end

    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx_s) begin
          state_d    = START;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          mismatch_d = 1'b0;
        end
      end

      START: begin
        if (decide && bit_maj) begin
          state_d    = IDLE;
          edge_cnt_d = '0;
        end else if (last_edge) begin
          state_d = DATA;
        end
      end

      DATA: begin
        if (decide) shift_d = {bit_maj, shift_q[WIDTH-1:1]};
        if (last_edge) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      PARITY: begin
        if (decide) mismatch_d = bit_maj ^ (^shift_q) ^ par_typ_q;
        if (last_edge) state_d = STOP;
      end

      STOP: begin
        if (decide) begin
          state_d    = IDLE;
          edge_cnt_d = '0;
          stp_err_d  = ~bit_maj;
          par_err_d  = par_en_q & mismatch_q;
          if (bit_maj && !(par_en_q && mismatch_q)) begin
            p_data_d = shift_q;
            valid_d  = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = valid_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;
  assign BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (WIDTH=8, OVS=8).
// Frames are bit-banged onto RX_IN one cycle at a time; every expected
// DATA_VALID pulse (word and cycle) and BUSY checkpoint is queued when the
// frame starts and compared by a negedge monitor when the DUT gets there.
module tb_uart_rx;

  localparam int WIDTH = 8;
  localparam int OVS   = 8;

  logic             CLK;
  logic             RST;
  logic             RX_IN;
  logic             PAR_EN;
  logic             PAR_TYP;
  logic [WIDTH-1:0] P_DATA;
  logic             DATA_VALID;
  logic             PAR_ERR;
  logic             STP_ERR;
  logic             BUSY;

  uart_rx #(.WIDTH(WIDTH), .OVS(OVS)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Cycle number: during the cycle after posedge k this reads k.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    int         cycle;
  } sb_t;

  typedef struct {
    int   cycle;
    logic busy;
  } bc_t;

  typedef struct {
    logic [7:0] data;
    logic       parEn;
    logic       parTyp;
    logic       corruptPar;
    logic       stopBit;
    logic       expParErr;
    logic       expStpErr;
    logic       expValid;
  } vec_t;

  sb_t        sbQ[$];
  bc_t        busyQ[$];
  sb_t        sbE;
  bc_t        bcE;
  vec_t       vecs[6];
  logic [7:0] expData;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard side: compare each valid pulse and each BUSY checkpoint.
  always @(negedge CLK) begin
    if (DATA_VALID) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected DATA_VALID", 32'(DATA_VALID), 32'd0);
      end else begin
        sbE = sbQ.pop_front();
        checkOutput("DATA_VALID cycle", cyc, sbE.cycle);
        checkOutput("P_DATA at valid", 32'(P_DATA), 32'(sbE.data));
      end
    end
    while (busyQ.size() > 0 && busyQ[0].cycle <= cyc) begin
      bcE = busyQ.pop_front();
      if (bcE.cycle < cyc) checkOutput("BUSY checkpoint missed", cyc, bcE.cycle);
      else checkOutput("BUSY", 32'(BUSY), 32'(bcE.busy));
    end
  end

  task automatic idle(input int k);
    repeat (k) @(posedge CLK);
    #1;
  endtask

  // Drive one full frame. The start bit falls in cycle n; T0 = n+3.
  task automatic applyStimulus(input logic [7:0] data, input logic parEn, input logic parTyp,
                               input logic corruptPar, input logic stopBit, input logic glitch,
                               input logic expValid);
    int   n;
    int   nbits;
    int   lat;
    logic pbit;
    logic v;
    sb_t  s;
    bc_t  b;
    pbit  = (^data) ^ parTyp ^ corruptPar;
    nbits = 2 + WIDTH + int'(parEn);
    lat   = (1 + WIDTH + int'(parEn)) * OVS + OVS / 2 + 2;
    n     = 0;
    PAR_EN  = parEn;
    PAR_TYP = parTyp;
    for (int bi = 0; bi < nbits; bi++) begin
      for (int o = 0; o < OVS; o++) begin
        @(posedge CLK);
        #1;
        if (bi == 0 && o == 0) begin
          n = cyc;
          if (expValid) begin
            s.data  = data;
            s.cycle = n + 3 + lat;
            sbQ.push_back(s);
          end
          b.cycle = n + 2;       b.busy = 1'b0; busyQ.push_back(b);
          b.cycle = n + 3;       b.busy = 1'b1; busyQ.push_back(b);
          b.cycle = n + 2 + lat; b.busy = 1'b1; busyQ.push_back(b);
          b.cycle = n + 3 + lat; b.busy = 1'b0; busyQ.push_back(b);
        end
        if (bi == 0) v = 1'b0;
        else if (bi <= WIDTH) v = data[bi-1];
        else if (parEn && bi == WIDTH + 1) v = pbit;
        else v = stopBit;
        if (glitch && bi >= 1 && bi <= WIDTH && o == OVS / 2 + 1) v = ~v;
        RX_IN = v;
      end
    end
    @(posedge CLK);
    #1;
    RX_IN = 1'b1;
  endtask

  logic [7:0] rstWord;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    expData = 8'h00;

    RST     = 1'b0;
    RX_IN   = 1'b1;
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;
    #12;
    checkOutput("reset P_DATA", 32'(P_DATA), 32'd0);
    checkOutput("reset DATA_VALID", 32'(DATA_VALID), 32'd0);
    checkOutput("reset PAR_ERR", 32'(PAR_ERR), 32'd0);
    checkOutput("reset STP_ERR", 32'(STP_ERR), 32'd0);
    checkOutput("reset BUSY", 32'(BUSY), 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    idle(5);
    checkOutput("post-reset BUSY", 32'(BUSY), 32'd0);

    // Table of single frames separated by idle line.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].data, vecs[i].parEn, vecs[i].parTyp, vecs[i].corruptPar,
                    vecs[i].stopBit, 1'b0, vecs[i].expValid);
      idle(24);
      if (vecs[i].expValid) expData = vecs[i].data;
      checkOutput($sformatf("vec%0d PAR_ERR", i), 32'(PAR_ERR), 32'(vecs[i].expParErr));
      checkOutput($sformatf("vec%0d STP_ERR", i), 32'(STP_ERR), 32'(vecs[i].expStpErr));
      checkOutput($sformatf("vec%0d P_DATA", i), 32'(P_DATA), 32'(expData));
      checkOutput($sformatf("vec%0d BUSY idle", i), 32'(BUSY), 32'd0);
    end

    // Two-cycle low glitch: START aborts, only BUSY pulses (T0..T0+5).
    begin
      int  n;
      bc_t b;
      @(posedge CLK);
      #1;
      RX_IN = 1'b0;
      n = cyc;
      b.cycle = n + 2; b.busy = 1'b0; busyQ.push_back(b);
      b.cycle = n + 3; b.busy = 1'b1; busyQ.push_back(b);
      b.cycle = n + 8; b.busy = 1'b1; busyQ.push_back(b);
      b.cycle = n + 9; b.busy = 1'b0; busyQ.push_back(b);
      @(posedge CLK);
      #1;
      @(posedge CLK);
      #1;
      RX_IN = 1'b1;
      idle(20);
      checkOutput("glitch PAR_ERR held", 32'(PAR_ERR), 32'd1);
      checkOutput("glitch STP_ERR held", 32'(STP_ERR), 32'd1);
      checkOutput("glitch P_DATA held", 32'(P_DATA), 32'(expData));
    end

    // Back-to-back frames with a one-cycle glitch at each data-bit centre.
    applyStimulus(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(8'hFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(24);
    expData = 8'hFE;
    checkOutput("b2b P_DATA", 32'(P_DATA), 32'(expData));
    checkOutput("b2b PAR_ERR", 32'(PAR_ERR), 32'd0);
    checkOutput("b2b STP_ERR", 32'(STP_ERR), 32'd0);

    // Leave a stop error pending, then reset in the middle of a frame.
    applyStimulus(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(24);
    checkOutput("pre-reset STP_ERR", 32'(STP_ERR), 32'd1);
    rstWord = 8'h77;
    PAR_EN  = 1'b0;
    for (int c = 0; c < 5 * OVS; c++) begin
      @(posedge CLK);
      #1;
      RX_IN = (c < OVS) ? 1'b0 : rstWord[c/OVS-1];
    end
    checkOutput("mid-frame BUSY", 32'(BUSY), 32'd1);
    @(posedge CLK);
    #1;
    RX_IN = rstWord[4];
    RST   = 1'b0;
    #1;
    checkOutput("async reset P_DATA", 32'(P_DATA), 32'd0);
    checkOutput("async reset DATA_VALID", 32'(DATA_VALID), 32'd0);
    checkOutput("async reset PAR_ERR", 32'(PAR_ERR), 32'd0);
    checkOutput("async reset STP_ERR", 32'(STP_ERR), 32'd0);
    checkOutput("async reset BUSY", 32'(BUSY), 32'd0);
    RX_IN = 1'b1;
    idle(4);
    RST = 1'b1;
    idle(10);
    expData = 8'h00;
    checkOutput("after reset P_DATA", 32'(P_DATA), 32'(expData));
    applyStimulus(8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(24);
    expData = 8'h77;
    checkOutput("fresh frame P_DATA", 32'(P_DATA), 32'(expData));
    checkOutput("fresh frame STP_ERR", 32'(STP_ERR), 32'd0);
    checkOutput("fresh frame PAR_ERR", 32'(PAR_ERR), 32'd0);

    idle(10);
    checkOutput("pending DATA_VALID count", sbQ.size(), 32'd0);
    checkOutput("pending BUSY checkpoints", busyQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
